aes_inv_round_sequencer: RTL

Control FSM for the AES-128 decryption round datapath: the InvShiftRows stage followed by 16 clocked Inv_SubBytes lanes, plus the four-column InvMixColumns stage.
- Owns the 128-bit cipher state register and performs AddRoundKey internally as an XOR.
- Issues round-key indices to the key store.
- Steps the external datapath through NR inverse rounds, then returns plaintext with a start/done handshake.
- Sits between the top-level decrypt interface and the shared round datapath.

---
 rtl/aes_inv_round_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/aes_inv_round_sequencer.sv
// AES-128 inverse-round control FSM; owns the cipher state and does AddRoundKey.
// Optional abort input is enabled by defining AES_INV_SEQ_ABORT_EN.
module aes_inv_round_sequencer #(
    parameter int NR         = 10,
    parameter int DP_LATENCY = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
`ifdef AES_INV_SEQ_ABORT_EN
    input  logic         abort,
`endif
    input  logic [0:127] ciphertext,
    input  logic [0:127] round_key,
    input  logic [0:127] dp_text_in,
    output logic         ready,
    output logic         done,
    output logic [0:127] plaintext,
    output logic [3:0]   key_idx,
    output logic         dp_op,
    output logic [0:127] dp_text_out
);

    typedef enum logic [2:0] {
        IDLE, LOAD, INIT_ADD, SUB, ADD, MIX, DONE
    } state_t;

    localparam logic [1:0] LAT   = 2'(DP_LATENCY);
    localparam logic [3:0] K_TOP = 4'(NR);
    localparam logic [3:0] R_TOP = 4'(NR - 1);

    state_t       state, state_n;
    logic [0:127] text, text_n;
    logic [0:127] pt_n;
    logic [3:0]   r, r_n;
    logic [3:0]   kidx_n;
    logic [1:0]   wait_q, wait_n;
    logic         abort_i;

`ifdef AES_INV_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign dp_text_out = text;

    always_comb begin
        state_n = state;
        text_n  = text;
        pt_n    = plaintext;
        r_n     = r;
        kidx_n  = key_idx;
        wait_n  = wait_q;
        ready   = 1'b0;
        done    = 1'b0;
        dp_op   = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start && !abort_i) begin
                    text_n  = ciphertext;
                    kidx_n  = K_TOP;
                    r_n     = R_TOP;
                    state_n = LOAD;
                end
            end
            LOAD: state_n = INIT_ADD;
            INIT_ADD: begin
                text_n  = text ^ round_key;
                kidx_n  = r;
                wait_n  = LAT;
                state_n = SUB;
            end
            SUB: begin
                if (wait_q == 2'd0) begin
                    text_n  = dp_text_in;
                    state_n = ADD;
                end else begin
                    wait_n = wait_q - 2'd1;
                end
            end
            ADD: begin
                text_n = text ^ round_key;
                // result is latched here so it is valid while done is high
                if (r == 4'd0) begin
                    pt_n    = text ^ round_key;
                    state_n = DONE;
                end else begin
                    wait_n  = LAT;
                    state_n = MIX;
                end
            end
            MIX: begin
                dp_op = 1'b1;
                if (wait_q == 2'd0) begin
                    text_n  = dp_text_in;
                    r_n     = r - 4'd1;
                    kidx_n  = r - 4'd1;
                    wait_n  = LAT;
                    state_n = SUB;
                end else begin
                    wait_n = wait_q - 2'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort_i && state != IDLE) begin
            state_n = IDLE;
            text_n  = '0;
            pt_n    = plaintext;
            r_n     = '0;
            kidx_n  = '0;
            wait_n  = '0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            text      <= '0;
            plaintext <= '0;
            r         <= '0;
            key_idx   <= '0;
            wait_q    <= '0;
        end else begin
            state     <= state_n;
            text      <= text_n;
            plaintext <= pt_n;
            r         <= r_n;
            key_idx   <= kidx_n;
            wait_q    <= wait_n;
        end
    end

endmodule
